vga_v_sync_timing: RTL and testbench
====================================

Name: vga_v_sync_timing

Overview:
- Downstream stage of the horizontal sync generator, clocked on the same pixel clock.
- Consumes the level `h_sync` waveform and treats each rising edge as the start of a line.
- Produces:
  - pixel X/Y coordinates;
  - the vertical sync pulse;
  - the active-video enable;
  - a frame-start strobe.
- Includes lock tracking, so the pixel pipeline only runs on a well-formed line stream.

Parameters:
- H_WHOLE, 1328: clocks per line; must equal the horizontal generator's whole-line count.
- H_ACTIVE, 1024: visible pixels per line; must be less than H_WHOLE.
- V_WHOLE, 806: lines per frame.
- V_ACTIVE, 768: visible lines.
- V_SYNC_START, 771: first line with vsync asserted.
- V_SYNC_END, 777: first line after vsync; must be greater than V_SYNC_START and no more than V_WHOLE.
- V_SYNC_ACTIVE_HIGH, 0: vsync asserted level; 0 means active-low.
- X_WIDTH, 11: pixel_x width; 2^X_WIDTH must be at least H_WHOLE.
- Y_WIDTH, 10: pixel_y width; 2^Y_WIDTH must be at least V_WHOLE.

Ports:
- control_clock  in  1  pixel clock.
- reset  in  1  synchronous, active-high.
- h_sync  in  1  horizontal sync level from the horizontal generator, synchronous to control_clock; its rising edge marks line start.
- pixel_x  out  X_WIDTH  column within the current line.
- pixel_y  out  Y_WIDTH  line within the current frame.
- video_on  out  1  high when (pixel_x, pixel_y) is in the visible area and the block is locked.
- v_sync  out  1  vertical sync.
- frame_start  out  1  one-cycle strobe, high in the first cycle of line 0.
- locked  out  1  block is tracking lines.
- lock_error  out  1  sticky error flag; only present as non-zero with the optional feature.

Behaviour:
Clock and reset:
- One clock, control_clock.
- Reset is synchronous and active-high; reset wins over every other event.

Reset values:
- pixel_x = 0, pixel_y = 0.
- video_on = 0, frame_start = 0, locked = 0, lock_error = 0.
- v_sync = inactive level, i.e. !V_SYNC_ACTIVE_HIGH.
- State = WAIT_LOCK.
- h_sync_d (registered copy of h_sync) = 1, so an h_sync already high at reset release is not seen as an edge.

Edge detect:
- rise = h_sync & !h_sync_d, evaluated combinationally.
- h_sync_d <= h_sync every cycle.

State machine: two states, WAIT_LOCK and RUN.

WAIT_LOCK:
- pixel_x and pixel_y hold 0.
- video_on = 0, locked = 0, v_sync is inactive.
- On rise: go to RUN; pixel_x <= 0, pixel_y <= 0, frame_start <= 1, locked <= 1.

RUN, on a clock edge with rise:
- pixel_x <= 0.
- pixel_y <= 0 if pixel_y == V_WHOLE-1, otherwise pixel_y + 1.
- frame_start <= 1 when the new pixel_y is 0.

RUN, on a clock edge without rise:
- pixel_x <= pixel_x + 1, saturating at H_WHOLE-1.
- pixel_y holds; frame_start <= 0.

Output timing:
- All outputs are registered.
- video_on and v_sync are computed from the next pixel_x and pixel_y, so they align cycle-exactly with the coordinates.
- Rise-to-output latency is 1 clock: the cycle in which h_sync is first high, registered at the next edge, gives pixel_x = 0.

Output equations:
- video_on = locked_next & (x_next < H_ACTIVE) & (y_next < V_ACTIVE).
- v_sync = asserted level when locked_next and V_SYNC_START <= y_next < V_SYNC_END; inactive otherwise.

Line length:
- A nominal line is exactly H_WHOLE clocks.
- The next rise therefore arrives when pixel_x == H_WHOLE-1.

Wrap-around:
- Line V_WHOLE-1 followed by a rise gives line 0 and a frame_start pulse.
- pixel_x never wraps on its own; only a rise resets it.

Optional Feature:
- Macro: VGA_LOCK_CHECK_EN.
- Defined, in RUN, a lock fault is either of:
  - rise with pixel_x != H_WHOLE-1 (short line);
  - pixel_x == H_WHOLE-1 with no rise (long line).
- A rise with pixel_x == H_WHOLE-1 is a legal line, not a fault.
- On a lock fault, at that edge:
  - state goes to WAIT_LOCK;
  - locked <= 0, video_on <= 0, v_sync goes inactive;
  - pixel_x and pixel_y go to 0;
  - lock_error <= 1, sticky until reset.
- The short-line rise itself is consumed; relock happens on the next rise.
- Undefined: no checking; lock_error is tied 0; RUN never exits except by reset; pixel_x saturates on long lines.

Test Plan:
1. Reset release, then h_sync with period 1328 (high 1072, low 256) -> first rise gives locked=1, frame_start=1, pixel_x=0, pixel_y=0 one clock after h_sync goes high; pixel_x reaches 1327 before the next rise.
2. Run a full frame -> video_on high exactly for x<1024 and y<768 (786432 cycles per frame); v_sync=0 on lines 771..776 only; frame_start pulses once per 806 lines; pixel_y wraps 805->0.
3. Hold h_sync high through reset release -> no lock until the first low-to-high transition; all outputs stay at reset values.
4. With VGA_LOCK_CHECK_EN, issue one line of 1000 clocks -> at the early rise: locked=0, lock_error=1, video_on=0; the next rise relocks with pixel_y=0; lock_error stays 1.
5. With VGA_LOCK_CHECK_EN, stop h_sync edges -> error asserts exactly when pixel_x reaches 1327. Without the macro -> pixel_x saturates at 1327, locked stays 1, lock_error stays 0.
6. Assert reset mid-frame on line 400, coinciding with a rise -> next cycle all outputs are at reset values and the state is WAIT_LOCK; the rise is ignored.

Source files
------------

// File: rtl/vga_v_sync_timing.sv
// Vertical timing stage: turns the h_sync level into pixel coordinates, vsync, video enable and frame strobe.
// Optional line-length lock checking is enabled by defining VGA_LOCK_CHECK_EN.
module vga_v_sync_timing #(
   parameter int H_WHOLE            = 1328,
   parameter int H_ACTIVE           = 1024,
   parameter int V_WHOLE            = 806,
   parameter int V_ACTIVE           = 768,
   parameter int V_SYNC_START       = 771,
   parameter int V_SYNC_END         = 777,
   parameter int V_SYNC_ACTIVE_HIGH = 0,
   parameter int X_WIDTH            = 11,
   parameter int Y_WIDTH            = 10
) (
   input  logic               control_clock,
   input  logic               reset,
   input  logic               h_sync,
   output logic [X_WIDTH-1:0] pixel_x,
   output logic [Y_WIDTH-1:0] pixel_y,
   output logic               video_on,
   output logic               v_sync,
   output logic               frame_start,
   output logic               locked,
   output logic               lock_error,
   output logic               dbg_state
);

   typedef enum logic {WAIT_LOCK = 1'b0, RUN = 1'b1} state_t;

   localparam logic [X_WIDTH-1:0] X_LAST  = X_WIDTH'(H_WHOLE - 1);
   localparam logic [Y_WIDTH-1:0] Y_LAST  = Y_WIDTH'(V_WHOLE - 1);
   localparam logic [X_WIDTH:0]   X_ACT   = (X_WIDTH+1)'(H_ACTIVE);
   localparam logic [Y_WIDTH:0]   Y_ACT   = (Y_WIDTH+1)'(V_ACTIVE);
   localparam logic [Y_WIDTH:0]   Y_VS0   = (Y_WIDTH+1)'(V_SYNC_START);
   localparam logic [Y_WIDTH:0]   Y_VS1   = (Y_WIDTH+1)'(V_SYNC_END);
   localparam logic               VS_ON   = (V_SYNC_ACTIVE_HIGH != 0);

   state_t               state_q, state_d;
   logic                 h_sync_q;
   logic [X_WIDTH-1:0]   x_q, x_d;
   logic [Y_WIDTH-1:0]   y_q, y_d;
   logic                 fs_q, fs_d;
   logic                 lock_q, lock_d;
   logic                 vid_q, vid_d;
   logic                 vs_q, vs_d;
   logic                 rise;

   assign rise = h_sync & ~h_sync_q;

`ifdef VGA_LOCK_CHECK_EN
   logic err_q, err_d;
   logic fault;
`endif

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      fs_d    = 1'b0;
      lock_d  = lock_q;
`ifdef VGA_LOCK_CHECK_EN
      err_d   = err_q;
      fault   = 1'b0;
`endif
      case (state_q)
         WAIT_LOCK: begin
            x_d    = '0;
            y_d    = '0;
            lock_d = 1'b0;
            if (rise) begin
               state_d = RUN;
               lock_d  = 1'b1;
               fs_d    = 1'b1;
            end
         end
         RUN: begin
`ifdef VGA_LOCK_CHECK_EN
            // A legal line has its rise exactly when x sits on the last column.
            fault = rise ? (x_q != X_LAST) : (x_q == X_LAST);
            if (fault) begin
               state_d = WAIT_LOCK;
               lock_d  = 1'b0;
               x_d     = '0;
               y_d     = '0;
               err_d   = 1'b1;
            end else
`endif
            if (rise) begin
               x_d  = '0;
               y_d  = (y_q == Y_LAST) ? '0 : y_q + Y_WIDTH'(1);
               fs_d = (y_d == '0);
            end else if (x_q != X_LAST) begin
               x_d = x_q + X_WIDTH'(1);
            end
         end
         default: state_d = WAIT_LOCK;
      endcase
      // Derived from next-cycle coordinates so they line up with pixel_x/pixel_y.
      vid_d = lock_d && ({1'b0, x_d} < X_ACT) && ({1'b0, y_d} < Y_ACT);
      vs_d  = (lock_d && ({1'b0, y_d} >= Y_VS0) && ({1'b0, y_d} < Y_VS1)) ? VS_ON : ~VS_ON;
   end

   always_ff @(posedge control_clock) begin
      if (reset) begin
         state_q  <= WAIT_LOCK;
         h_sync_q <= 1'b1;
         x_q      <= '0;
         y_q      <= '0;
         fs_q     <= 1'b0;
         lock_q   <= 1'b0;
         vid_q    <= 1'b0;
         vs_q     <= ~VS_ON;
`ifdef VGA_LOCK_CHECK_EN
         err_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         h_sync_q <= h_sync;
         x_q      <= x_d;
         y_q      <= y_d;
         fs_q     <= fs_d;
         lock_q   <= lock_d;
         vid_q    <= vid_d;
         vs_q     <= vs_d;
`ifdef VGA_LOCK_CHECK_EN
         err_q    <= err_d;
`endif
      end
   end

   assign pixel_x     = x_q;
   assign pixel_y     = y_q;
   assign video_on    = vid_q;
   assign v_sync      = vs_q;
   assign frame_start = fs_q;
   assign locked      = lock_q;
   assign dbg_state   = state_q;
`ifdef VGA_LOCK_CHECK_EN
   assign lock_error  = err_q;
`else
   assign lock_error  = 1'b0;
`endif

endmodule

// File: tb/tb_vga_v_sync_timing.sv
// Bench for vga_v_sync_timing with a reduced raster; a line/frame-count model checks every cycle.
module tb_vga_v_sync_timing;
   localparam int HW = 40, HA = 30, VW = 12, VA = 8, VSS = 9, VSE = 11, VSH = 0;
   localparam int XW = 6, YW = 4;
`ifdef VGA_LOCK_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic          control_clock = 1'b0;
   logic          reset = 1'b1;
   logic          h_sync = 1'b0;
   logic [XW-1:0] pixel_x;
   logic [YW-1:0] pixel_y;
   logic          video_on, v_sync, frame_start, locked, lock_error, dbg_state;

   vga_v_sync_timing #(
      .H_WHOLE(HW), .H_ACTIVE(HA), .V_WHOLE(VW), .V_ACTIVE(VA),
      .V_SYNC_START(VSS), .V_SYNC_END(VSE), .V_SYNC_ACTIVE_HIGH(VSH),
      .X_WIDTH(XW), .Y_WIDTH(YW)
   ) dut (
      .control_clock(control_clock), .reset(reset), .h_sync(h_sync),
      .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on), .v_sync(v_sync),
      .frame_start(frame_start), .locked(locked), .lock_error(lock_error),
      .dbg_state(dbg_state)
   );

   always #5 control_clock = ~control_clock;

   int n_cmp = 0, n_err = 0;
   bit chk_en = 1'b0, cnt_en = 1'b0;
   int vid_cnt = 0, vs_cnt = 0, fs_cnt = 0;

   // Model: lines since lock and clocks since the last rise.
   bit m_locked, m_err, m_fs, m_hsd;
   int m_cnt, m_line;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   task automatic model_step(input bit rst_v, input bit hs_v);
      bit rise, fault;
      int x;
      if (rst_v) begin
         m_locked = 0; m_err = 0; m_fs = 0; m_hsd = 1; m_cnt = 0; m_line = 0;
         return;
      end
      rise  = hs_v && !m_hsd;
      m_hsd = hs_v;
      m_fs  = 0;
      if (!m_locked) begin
         if (rise) begin
            m_locked = 1; m_cnt = 0; m_line = 0; m_fs = 1;
         end
      end else begin
         x     = (m_cnt > HW-1) ? HW-1 : m_cnt;
         fault = CHK && (rise ? (x != HW-1) : (x == HW-1));
         if (fault) begin
            m_locked = 0; m_err = 1; m_cnt = 0; m_line = 0;
         end else if (rise) begin
            m_cnt  = 0;
            m_line = (m_line + 1) % VW;
            m_fs   = (m_line == 0);
         end else begin
            m_cnt++;
         end
      end
   endtask

   task automatic cycle(input bit hs_v, input bit rst_v);
      h_sync = hs_v;
      reset  = rst_v;
      @(posedge control_clock);
      model_step(rst_v, hs_v);
      #1;
   endtask

   task automatic drive_line(input int len, input int hi);
      for (int i = 0; i < len; i++) cycle(i < hi, 1'b0);
   endtask

   always @(negedge control_clock) begin
      if (chk_en) begin
         int ex, ey;
         ex = m_locked ? ((m_cnt > HW-1) ? HW-1 : m_cnt) : 0;
         ey = m_locked ? m_line : 0;
         chk("pixel_x", pixel_x, ex);
         chk("pixel_y", pixel_y, ey);
         chk("video_on", video_on, m_locked && ex < HA && ey < VA);
         chk("v_sync", v_sync, (m_locked && ey >= VSS && ey < VSE) ? VSH : !VSH);
         chk("frame_start", frame_start, m_fs);
         chk("locked", locked, m_locked);
         chk("lock_error", lock_error, m_err);
         chk("dbg_state", dbg_state, m_locked);
      end
      if (cnt_en) begin
         vid_cnt += video_on;
         vs_cnt  += (v_sync == VSH);
         fs_cnt  += frame_start;
      end
   end

   initial begin
      // Reset, then literal reset values.
      cycle(1'b0, 1'b1);
      chk_en = 1'b1;
      cycle(1'b0, 1'b1);
      cycle(1'b0, 1'b0);
      @(negedge control_clock); #1;
      chk("rst_pixel_x", pixel_x, 0);
      chk("rst_locked", locked, 0);
      chk("rst_v_sync", v_sync, 1);
      chk("rst_video_on", video_on, 0);

      // First rise locks, then one whole nominal frame is tallied.
      cycle(1'b1, 1'b0);
      cnt_en = 1'b1;
      @(negedge control_clock); #1;
      chk("lock_locked", locked, 1);
      chk("lock_frame_start", frame_start, 1);
      chk("lock_pixel_x", pixel_x, 0);
      chk("lock_pixel_y", pixel_y, 0);
      for (int i = 1; i < HW; i++) cycle(i < 32, 1'b0);
      for (int l = 1; l < VW; l++) drive_line(HW, 32);
      @(negedge control_clock); #1;
      cnt_en = 1'b0;
      chk("last_pixel_x", pixel_x, 39);
      chk("last_pixel_y", pixel_y, 11);
      chk("frame_video_cycles", vid_cnt, 240);
      chk("frame_vsync_cycles", vs_cnt, 80);
      chk("frame_start_pulses", fs_cnt, 1);
      cycle(1'b1, 1'b0);
      @(negedge control_clock); #1;
      chk("wrap_pixel_y", pixel_y, 0);
      chk("wrap_frame_start", frame_start, 1);
      for (int i = 1; i < HW; i++) cycle(i < 32, 1'b0);

      // Run to line 5, then reset coinciding with a rise.
      for (int l = 1; l < 5; l++) drive_line(HW, 32);
      cycle(1'b0, 1'b0);
      cycle(1'b1, 1'b1);
      @(negedge control_clock); #1;
      chk("mid_rst_locked", locked, 0);
      chk("mid_rst_pixel_y", pixel_y, 0);
      chk("mid_rst_state", dbg_state, 0);
      // h_sync held high through release: no lock.
      for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0);
      @(negedge control_clock); #1;
      chk("hold_high_locked", locked, 0);
      chk("hold_high_v_sync", v_sync, 1);
      cycle(1'b0, 1'b0);
      drive_line(HW, 32);
      drive_line(HW, 32);

      // Short line, then relock.
      drive_line(25, 10);
      cycle(1'b1, 1'b0);
      @(negedge control_clock); #1;
      if (CHK) begin
         chk("short_locked", locked, 0);
         chk("short_lock_error", lock_error, 1);
         chk("short_video_on", video_on, 0);
      end else begin
         chk("short_locked", locked, 1);
         chk("short_lock_error", lock_error, 0);
      end
      for (int i = 1; i < HW; i++) cycle(i < 32, 1'b0);
      cycle(1'b1, 1'b0);
      @(negedge control_clock); #1;
      chk("relock_locked", locked, 1);
      chk("relock_lock_error", lock_error, CHK);

      // No further edges: long line.
      for (int i = 1; i < 2*HW; i++) cycle(1'b0, 1'b0);
      @(negedge control_clock); #1;
      chk("long_locked", locked, !CHK);
      chk("long_pixel_x", pixel_x, CHK ? 0 : 39);
      chk("long_lock_error", lock_error, CHK);

      // Randomized lines with occasional resets and malformed lengths.
      for (int l = 0; l < 150; l++) begin
         int len, hi;
         if ($urandom_range(0, 99) < 3) cycle(1'(($urandom_range(0, 1))), 1'b1);
         len = ($urandom_range(0, 99) < 85) ? HW : $urandom_range(2, 2*HW);
         hi  = $urandom_range(1, len-1);
         drive_line(len, hi);
      end
      // A full clean frame to close out.
      for (int l = 0; l < VW + 1; l++) drive_line(HW, $urandom_range(1, HW-1));
      @(negedge control_clock); #1;
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
